// File: rtl/bus_arb_pkg.sv
// Shared definitions for the N-client bus arbiter: FSM state encoding,
// arbitration mode codes and the client-index width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  localparam logic ARB_STRICT = 1'b0;
  localparam logic ARB_RR     = 1'b1;

  // A single client still needs a 1-bit index so the grant port never collapses.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_winner_select.sv
// Combinational winner picker: strict priority (lowest map value, lowest index on ties)
// or round robin starting just after rr_ptr.
module arb_winner_select
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0]       rq,
  input  logic                         mode,
  input  logic [NUM_CLIENTS*IDX_W-1:0] prio_map,
  input  logic [IDX_W-1:0]             rr_ptr,
  output logic [IDX_W-1:0]             winner,
  output logic                         any_rq
);

  logic [IDX_W-1:0] strict_win;
  logic [IDX_W-1:0] best_pri;
  logic             strict_found;
  logic [IDX_W-1:0] rr_win;
  logic             rr_found;
  logic [IDX_W:0]   cand;

  assign any_rq = |rq;

  // Strict '<' keeps the earlier (lower) index when priorities tie.
  always_comb begin
    strict_win   = '0;
    best_pri     = '0;
    strict_found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (rq[i] && (!strict_found || (prio_map[i*IDX_W +: IDX_W] < best_pri))) begin
        strict_found = 1'b1;
        best_pri     = prio_map[i*IDX_W +: IDX_W];
        strict_win   = IDX_W'(i);
      end
    end
  end

  // One extra bit on cand lets rr_ptr+k exceed N before folding back into range.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CLIENTS)) begin
        cand = cand - (IDX_W+1)'(NUM_CLIENTS);
      end
      if (!rr_found && rq[cand[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = cand[IDX_W-1:0];
      end
    end
  end

  assign winner = (mode == ARB_RR) ? rr_win : strict_win;

endmodule

// File: rtl/bus_arbiter_nch.sv
// N-client to single-server bus arbiter with a grant-locking FSM, strict/RR
// arbitration, optional transaction timeout and combinational ack/data routing.
module bus_arbiter_nch
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ARB_MODE       = 0,
  parameter logic [NUM_CLIENTS*idx_width(NUM_CLIENTS)-1:0] PRIORITY_MAP = 8'hE4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CLIENTS-1:0]               client_rq,
  input  logic [NUM_CLIENTS-1:0]               client_wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]    client_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]    client_dataW,
  output logic [NUM_CLIENTS-1:0]               client_ack,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0]    client_dataR,
  output logic                                 server_rq,
  input  logic                                 server_ack,
  output logic                                 server_wr_ni,
  output logic [ADDR_WIDTH-1:0]                server_address,
  output logic [DATA_WIDTH-1:0]                server_dataW,
  input  logic [DATA_WIDTH-1:0]                server_dataR,
  output logic                                 grant_valid,
  output logic [idx_width(NUM_CLIENTS)-1:0]    grant_idx,
  output logic                                 timeout_err
);

  localparam int          IDX_W   = idx_width(NUM_CLIENTS);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [15:0]      count_reg, count_next;
  logic             timeout_err_reg, timeout_err_next;

  logic             mode_sel;
  logic [IDX_W-1:0] winner;
  logic             any_rq;
  logic             busy;
  logic             granted_rq;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] dataw_arr [NUM_CLIENTS];

  assign mode_sel = (ARB_MODE == 1) ? ARB_RR : ARB_STRICT;

  arb_winner_select #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_winner (
    .rq       (client_rq),
    .mode     (mode_sel),
    .prio_map (PRIORITY_MAP),
    .rr_ptr   (rr_ptr_reg),
    .winner   (winner),
    .any_rq   (any_rq)
  );

  // Reset gates every output combinationally so nothing leaks during the reset cycle.
  assign busy       = (state_reg == BUSY) && !reset;
  assign granted_rq = client_rq[grant_idx_reg];

  always_comb begin
    state_next       = state_reg;
    grant_idx_next   = grant_idx_reg;
    rr_ptr_next      = rr_ptr_reg;
    count_next       = count_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (any_rq) begin
          grant_idx_next = winner;
          rr_ptr_next    = winner;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        count_next = count_reg + 16'd1;
        // Ack takes precedence over both abort and timeout.
        if (server_ack) begin
          state_next = RELEASE;
        end else if (!granted_rq) begin
          state_next = IDLE;
        end else if (TO_EN && (count_reg == TO_LAST)) begin
          state_next       = RELEASE;
          timeout_err_next = 1'b1;
        end
      end
      RELEASE: begin
        count_next = '0;
        state_next = IDLE;
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_idx_reg   <= '0;
      rr_ptr_reg      <= IDX_W'(NUM_CLIENTS - 1);
      count_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_idx_reg   <= grant_idx_next;
      rr_ptr_reg      <= rr_ptr_next;
      count_reg       <= count_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    assign addr_arr[gi]  = client_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dataw_arr[gi] = client_dataW[gi*DATA_WIDTH +: DATA_WIDTH];
    assign client_ack[gi] = busy && server_ack && (grant_idx_reg == IDX_W'(gi));
    assign client_dataR[gi*DATA_WIDTH +: DATA_WIDTH] = client_ack[gi] ? server_dataR : '0;
  end

  assign server_rq      = busy && granted_rq;
  assign server_wr_ni   = busy && client_wr_ni[grant_idx_reg];
  assign server_address = busy ? addr_arr[grant_idx_reg]  : '0;
  assign server_dataW   = busy ? dataw_arr[grant_idx_reg] : '0;

  assign grant_valid = busy;
  assign grant_idx   = reset ? '0 : grant_idx_reg;
  assign timeout_err = timeout_err_reg && !reset;

endmodule
